divide: RTL and testbench

Sequential restoring shift-subtract divider, the inverse counterpart of the team's shift-add multiplier. It accepts an unsigned 16-bit dividend and 8-bit divisor on a start pulse. It resolves one quotient bit per clock and presents a registered quotient and remainder with a one-cycle done pulse. It sits beside the multiplier in the arithmetic datapath and uses the same clock.

---
 rtl/divide_pkg.sv | 20 ++
 rtl/divide_if.sv | 30 +++
 rtl/div_step.sv | 38 +++
 rtl/divide.sv | 126 ++++++++++++
 tb/tb_divide.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/divide_pkg.sv
// Shared definitions for the shift-subtract divider: default widths,
// state encoding and the step-counter width helper.
package divide_pkg;

  localparam int unsigned DIVIDEND_W_DEF = 16;
  localparam int unsigned DIVISOR_W_DEF  = 8;

  // 2'b11 is unused; the FSM treats it as IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Width of the step counter, never below one bit.
  function automatic int unsigned cnt_w(input int unsigned w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/divide_if.sv
// Request/result bundle for the divider.
//   master : Start, Dividend, Divisor out; Busy, Done, DivZero, Quotient, Remainder in
//   slave  : the reverse
interface divide_if
  import divide_pkg::*;
#(
  parameter int unsigned DIVIDEND_W = DIVIDEND_W_DEF,
  parameter int unsigned DIVISOR_W  = DIVISOR_W_DEF
) ();

  logic                  Start;
  logic [DIVIDEND_W-1:0] Dividend;
  logic [DIVISOR_W-1:0]  Divisor;
  logic                  Busy;
  logic                  Done;
  logic                  DivZero;
  logic [DIVIDEND_W-1:0] Quotient;
  logic [DIVISOR_W-1:0]  Remainder;

  modport master (
    output Start, Dividend, Divisor,
    input  Busy, Done, DivZero, Quotient, Remainder
  );

  modport slave (
    input  Start, Dividend, Divisor,
    output Busy, Done, DivZero, Quotient, Remainder
  );

endinterface

// File: rtl/div_step.sv
// One restoring divide step (combinational).
//   r_in   : current partial remainder (DIVISOR_W+1 bits)
//   bit_in : next dividend bit shifted in
//   d      : divisor
//   r_out  : next partial remainder
//   q_bit  : resolved quotient bit
module div_step #(
  parameter int unsigned DIVISOR_W = 8
) (
  input  logic [DIVISOR_W:0]   r_in,
  input  logic                 bit_in,
  input  logic [DIVISOR_W-1:0] d,
  output logic [DIVISOR_W:0]   r_out,
  output logic                 q_bit
);

  localparam int unsigned RW = DIVISOR_W + 1;
  localparam int unsigned TW = DIVISOR_W + 2;

  logic [TW-1:0] t;
  logic [TW-1:0] d_ext;

  // The full partial remainder is shifted in; its MSB is always zero, so
  // this matches the narrower {r[W-1:0], bit} form while keeping every bit live.
  assign t     = {r_in, bit_in};
  assign d_ext = TW'(d);

  // Compare/subtract: keep the difference when it does not underflow.
  always_comb begin
    r_out = RW'(t);
    q_bit = 1'b0;
    if (t >= d_ext) begin
      r_out = RW'(t - d_ext);
      q_bit = 1'b1;
    end
  end

endmodule

// File: rtl/divide.sv
// Sequential restoring divider: one quotient bit per clock, registered
// results with a one-cycle Done pulse.
//   CLK_in : clock, rising edge
//   RST_in : asynchronous active-high reset
//   bus    : divide_if slave (Start/Dividend/Divisor in; Busy/Done/DivZero/Quotient/Remainder out)
module divide
  import divide_pkg::*;
#(
  parameter int unsigned DIVIDEND_W = DIVIDEND_W_DEF,
  parameter int unsigned DIVISOR_W  = DIVISOR_W_DEF
) (
  input  logic     CLK_in,
  input  logic     RST_in,
  divide_if.slave  bus
);

  localparam int unsigned COUNT_W = cnt_w(DIVIDEND_W);

  state_e                state_q, state_d;
  logic [COUNT_W-1:0]    count_q, count_d;
  logic [DIVIDEND_W-1:0] q_q, q_d;
  logic [DIVISOR_W:0]    r_q, r_d;
  logic [DIVISOR_W-1:0]  d_q, d_d;
  logic                  zflag_q, zflag_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  div_zero_q, div_zero_d;
  logic [DIVIDEND_W-1:0] quotient_q, quotient_d;
  logic [DIVISOR_W-1:0]  remainder_q, remainder_d;

  logic [DIVISOR_W:0]    r_next;
  logic                  q_bit;

  div_step #(.DIVISOR_W(DIVISOR_W)) u_step (
    .r_in   (r_q),
    .bit_in (q_q[DIVIDEND_W-1]),
    .d      (d_q),
    .r_out  (r_next),
    .q_bit  (q_bit)
  );

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    q_d         = q_q;
    r_d         = r_q;
    d_d         = d_q;
    zflag_d     = zflag_q;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    div_zero_d  = div_zero_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;

    unique case (state_q)
      ST_RUN: begin
        busy_d  = 1'b1;
        q_d     = {q_q[DIVIDEND_W-2:0], q_bit};
        r_d     = r_next;
        count_d = count_q + COUNT_W'(1);
        if (count_q == COUNT_W'(DIVIDEND_W - 1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        busy_d      = 1'b1;
        done_d      = 1'b1;
        quotient_d  = q_q;
        remainder_d = r_q[DIVISOR_W-1:0];
        div_zero_d  = zflag_q;
        state_d     = ST_IDLE;
      end
      default: begin
        // busy_q is still high during the Done cycle, which blocks a Start there.
        if (bus.Start && !busy_q) begin
          q_d     = bus.Dividend;
          r_d     = '0;
          d_d     = bus.Divisor;
          zflag_d = (bus.Divisor == '0);
          count_d = '0;
          busy_d  = 1'b1;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge CLK_in or posedge RST_in) begin
    if (RST_in) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      q_q         <= '0;
      r_q         <= '0;
      d_q         <= '0;
      zflag_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      div_zero_q  <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      q_q         <= q_d;
      r_q         <= r_d;
      d_q         <= d_d;
      zflag_q     <= zflag_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      div_zero_q  <= div_zero_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
    end
  end

  assign bus.Busy      = busy_q;
  assign bus.Done      = done_q;
  assign bus.DivZero   = div_zero_q;
  assign bus.Quotient  = quotient_q;
  assign bus.Remainder = remainder_q;

endmodule

// File: tb/tb_divide.sv
// Self-checking bench for the divider: directed cases plus random operands
// compared against an arithmetic reference model.
module tb_divide;

  logic clk;
  logic rst;

  divide_if bus ();

  divide dut (
    .CLK_in (clk),
    .RST_in (rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests;
  int n_fail;
  logic [15:0] last_q;
  logic [7:0]  last_r;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"}, 32'(bus.Busy), 32'd0);
    check({tag, "_done"}, 32'(bus.Done), 32'd0);
    check({tag, "_dz"},   32'(bus.DivZero), 32'd0);
    check({tag, "_q"},    32'(bus.Quotient), 32'd0);
    check({tag, "_r"},    32'(bus.Remainder), 32'd0);
  endtask

  // Issue one division, wait for Done, compare against the model.
  task automatic do_div(input logic [15:0] a, input logic [7:0] b, input string tag);
    logic [15:0] eq;
    logic [7:0]  er;
    int          lat;
    bit          seen;
    if (b == 8'd0) begin
      eq = 16'hFFFF;
      er = a[7:0];
    end else begin
      eq = 16'(a / 16'(b));
      er = 8'(a % 16'(b));
    end
    bus.Start    = 1'b1;
    bus.Dividend = a;
    bus.Divisor  = b;
    tick();
    bus.Start    = 1'b0;
    bus.Dividend = 16'($urandom);
    bus.Divisor  = 8'($urandom);
    lat  = 1;
    seen = 1'b0;
    check({tag, "_busy_run"}, 32'(bus.Busy), 32'd1);
    while (!seen && lat < 40) begin
      tick();
      lat++;
      if (lat == 9) begin
        check({tag, "_hold_q"}, 32'(bus.Quotient), 32'(last_q));
        check({tag, "_hold_r"}, 32'(bus.Remainder), 32'(last_r));
      end
      if (bus.Done) seen = 1'b1;
    end
    check({tag, "_latency"}, 32'(lat), 32'd18);
    check({tag, "_q"},  32'(bus.Quotient), 32'(eq));
    check({tag, "_r"},  32'(bus.Remainder), 32'(er));
    check({tag, "_dz"}, 32'(bus.DivZero), 32'(b == 8'd0));
    if (b != 8'd0) begin
      check({tag, "_inv"}, 32'(bus.Quotient) * 32'(b) + 32'(bus.Remainder), 32'(a));
      check({tag, "_rltd"}, 32'(bus.Remainder < b), 32'd1);
    end
    tick();
    check({tag, "_done_pulse"}, 32'(bus.Done), 32'd0);
    check({tag, "_busy_idle"}, 32'(bus.Busy), 32'd0);
    last_q = eq;
    last_r = er;
  endtask

  initial begin
    int lat;
    int n_done;
    n_tests      = 0;
    n_fail       = 0;
    last_q       = 16'd0;
    last_r       = 8'd0;
    rst          = 1'b1;
    bus.Start    = 1'b0;
    bus.Dividend = 16'd0;
    bus.Divisor  = 8'd0;

    tick();
    tick();
    check_zero_outputs("reset");
    rst = 1'b0;
    tick();
    check_zero_outputs("post_reset");

    do_div(16'd200, 8'd7, "d200_7");
    do_div(16'd65535, 8'd255, "d65535_255");
    repeat (3) tick();
    check("hold_idle_q", 32'(bus.Quotient), 32'd257);
    do_div(16'd5, 8'd9, "d5_9");
    do_div(16'd1000, 8'd0, "d1000_0");

    // Start during RUN and during the Done cycle must both be ignored.
    bus.Start    = 1'b1;
    bus.Dividend = 16'd200;
    bus.Divisor  = 8'd7;
    tick();
    bus.Start = 1'b0;
    repeat (4) tick();
    bus.Start    = 1'b1;
    bus.Dividend = 16'd100;
    bus.Divisor  = 8'd3;
    tick();
    bus.Start = 1'b0;
    lat = 6;
    while (!bus.Done && lat < 40) begin
      tick();
      lat++;
    end
    check("ign_latency", 32'(lat), 32'd18);
    check("ign_q", 32'(bus.Quotient), 32'd28);
    check("ign_r", 32'(bus.Remainder), 32'd4);
    bus.Start    = 1'b1;
    bus.Dividend = 16'd100;
    bus.Divisor  = 8'd3;
    tick();
    bus.Start = 1'b0;
    check("ign_done_busy0", 32'(bus.Busy), 32'd0);
    tick();
    check("ign_done_busy1", 32'(bus.Busy), 32'd0);
    n_done = 0;
    repeat (25) begin
      tick();
      if (bus.Done) n_done++;
    end
    check("ign_extra_done", 32'(n_done), 32'd0);
    check("ign_hold_q", 32'(bus.Quotient), 32'd28);
    last_q = 16'd28;
    last_r = 8'd4;

    // Reset in the middle of RUN clears everything immediately.
    bus.Start    = 1'b1;
    bus.Dividend = 16'd200;
    bus.Divisor  = 8'd7;
    tick();
    bus.Start = 1'b0;
    repeat (8) tick();
    rst = 1'b1;
    #1;
    check_zero_outputs("mid_rst");
    tick();
    rst = 1'b0;
    n_done = 0;
    repeat (25) begin
      tick();
      if (bus.Done) n_done++;
    end
    check("mid_rst_no_done", 32'(n_done), 32'd0);
    check("mid_rst_busy", 32'(bus.Busy), 32'd0);
    last_q = 16'd0;
    last_r = 8'd0;
    do_div(16'd1, 8'd1, "d1_1");

    // Random operands with nonzero divisor.
    for (int i = 0; i < 500; i++) begin
      do_div(16'($urandom), 8'($urandom_range(255, 1)), $sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
